// File: rtl/serial_adder_ctrl_if.sv
// Parallel-bus side of the serial adder sequencer: operand request and result signals.
// master drives the request, slave (the sequencer) drives the result.
interface serial_adder_ctrl_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: shifts a captured operand pair LSB-first through a full adder.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_CTRL_OVF_EN.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    serial_adder_ctrl_if.slave bus
);
    localparam int unsigned     CntW    = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;

    logic             s;
    logic             c_next;
    logic             accept;
    logic             last;
    logic [WIDTH-1:0] sum_shift;

    assign accept = (state_q == StIdle) && bus.start;
    assign last   = (state_q == StShift) && (cnt_q == LastCnt);
    assign s      = a_q[0] ^ b_q[0] ^ c_q;
    assign c_next = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (bus.start) state_d = StShift;
            StShift: if (cnt_q == LastCnt) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state_q)
            StShift: bus.busy = 1'b1;
            StDone: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
            end
            default: ;
        endcase
    end

    // Partial sum holds the WIDTH-1 bits already produced; the current bit s completes it.
    if (WIDTH == 1) begin : g_sum_w1
        assign sum_shift = s;
    end else begin : g_sum_wn
        logic [WIDTH-2:0] psum_q, psum_d;

        always_comb begin
            psum_d = psum_q;
            if (accept) begin
                psum_d = '0;
            end else if (state_q == StShift) begin
                psum_d = sum_shift[WIDTH-1:1];
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                psum_q <= '0;
            end else begin
                psum_q <= psum_d;
            end
        end

        assign sum_shift = {s, psum_q};
    end

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        c_d    = c_q;
        cnt_d  = cnt_q;
        sum_d  = sum_q;
        cout_d = cout_q;
        if (accept) begin
            a_d   = bus.a;
            b_d   = bus.b;
            c_d   = bus.cin;
            cnt_d = '0;
        end else if (state_q == StShift) begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            c_d   = c_next;
            cnt_d = cnt_q + CntW'(1);
            if (last) begin
                sum_d  = sum_shift;
                cout_d = c_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= 1'b0;
            cnt_q  <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            c_q    <= c_d;
            cnt_q  <= cnt_d;
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

`ifdef SERIAL_ADDER_CTRL_OVF_EN
    logic ovf_q, ovf_d;

    // Carry into the MSB is a^b^s of that bit; overflow when it differs from the carry out.
    always_comb begin
        ovf_d = ovf_q;
        if (last) begin
            ovf_d = a_q[0] ^ b_q[0] ^ s ^ c_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif
endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Sequencer for the bit-serial adder datapath (full adder, carry flip-flop, operand and sum shift registers). It accepts a parallel operand pair on a start pulse and shifts the operands LSB-first through the full adder for exactly WIDTH cycles. It then presents the parallel sum and carry-out with a one-cycle done strobe. It sits between the parallel-bus side of the design and the serial adder, and owns all shift enables, the carry flop and the bit counter.

## Interface
- WIDTH, default 4: operand/sum width in bits; legal range 1..32.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high; sampled only on the rising edge of clk.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  WIDTH  operand A, captured on an accepted start.
- b  input  WIDTH  operand B, captured on an accepted start.
- cin  input  1  carry-in, captured on an accepted start.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle strobe; result valid.
- sum  output  WIDTH  registered result; held until the next completion.
- cout  output  1  registered carry-out of the MSB.
- ovf  output  1  registered signed-overflow flag; see Configuration.

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset forces IDLE, the bit counter to 0, all internal shift registers and the carry flop to 0, and busy/done/sum/cout/ovf to 0.
- IDLE, start=1: capture a, b and cin into the A shift register, B shift register and carry flop; clear counter; go to SHIFT. With start=0, stay in IDLE.
- SHIFT, each edge:
  - s = A[0]^B[0]^c; c <= majority(A[0],B[0],c).
  - A and B shift right, zero-filled; s enters the MSB of the internal sum shift register.
  - Counter increments.
  - On the edge where the counter reaches WIDTH-1, go to DONE and copy the completed sum, the final carry and the overflow to the output registers.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- start is ignored in SHIFT and DONE; there is no queueing.
- Arithmetic: sum = (a + b + cin) mod 2^WIDTH; cout = bit WIDTH of the full result. The counter width is clog2(WIDTH)+1.
- sum, cout and ovf change only on DONE entry or reset; they stay stable throughout a following operation.

## Timing
- Edge 0 samples start in IDLE. Edges 1..WIDTH perform the bit additions. done is high between edge WIDTH and edge WIDTH+1.
- busy rises after edge 0 and falls after edge WIDTH+1.
- Latency: start edge to the done-high cycle is WIDTH cycles. Minimum start-to-start spacing is WIDTH+2 cycles. The earliest next accepted start is at edge WIDTH+2, when the FSM is back in IDLE.
- WIDTH=1: a single SHIFT cycle, then DONE.
- Reset asserted mid-operation (SHIFT or DONE): the next edge goes to IDLE with all outputs 0. The partial result is discarded and no done strobe is produced.
- reset and start high on the same edge: reset wins.

## Configuration
- Macro: SERIAL_ADDER_CTRL_OVF_EN.
- Defined: on the final SHIFT edge, ovf is registered as carry-into-MSB XOR carry-out, i.e. A[0]^B[0]^s^c_next for that bit. It updates together with sum.
- Not defined: the overflow logic is not synthesised and ovf is tied to 0. The port remains present in both cases.

## Test plan
- WIDTH=4, a=5, b=3, cin=0 -> sum=8, cout=0, ovf=1 (macro on) / 0 (off); done is high exactly 4 cycles after the start edge.
- WIDTH=4, a=15, b=1, cin=0 -> sum=0, cout=1, ovf=0; a=7, b=0, cin=1 -> sum=8, cout=0, ovf=1.
- Start with a=2, b=2; pulse start with a=9, b=9 during SHIFT -> the second start is ignored; sum=4, exactly one done pulse.
- Start a=6, b=6; assert reset at edge 2 -> the next cycle shows busy=0, sum=0, cout=0, and no done pulse; a fresh a=1, b=1 op then gives sum=2.
- Back-to-back: hold start high continuously with a=3, b=4, cin=1 -> ops are accepted every 6 cycles; sum=8 each time; sum is stable between done pulses.
- WIDTH=1 build: a=1, b=1, cin=1 -> sum=1, cout=1; done is 1 cycle after start.
